// File: rtl/conv_ctrl_tiled_if.sv
// Handshake and strobe bundle between the tiled convolution controller and its
// operand feeders, MAC array, partial-sum memory and output sink.
interface conv_ctrl_tiled_if #(
    parameter int AW = 20
);
    logic          a_valid;
    logic          a_ready;
    logic          b_valid;
    logic          b_ready;
    logic          write_a;
    logic          write_b;
    logic          mac_valid;
    logic          mac_accumulate_internal;
    logic          mac_accumulate_with_0;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_write_addr;
    logic [AW-1:0] mem_read_addr;
    logic          output_valid;
    logic          output_ready;
    logic [31:0]   output_x;
    logic [31:0]   output_y;
    logic [31:0]   output_ch;

    modport master (
        input  a_valid, b_valid, output_ready,
        output a_ready, b_ready, write_a, write_b,
        output mac_valid, mac_accumulate_internal, mac_accumulate_with_0,
        output mem_we, mem_re, mem_write_addr, mem_read_addr,
        output output_valid, output_x, output_y, output_ch
    );

    modport slave (
        output a_valid, b_valid, output_ready,
        input  a_ready, b_ready, write_a, write_b,
        input  mac_valid, mac_accumulate_internal, mac_accumulate_with_0,
        input  mem_we, mem_re, mem_write_addr, mem_read_addr,
        input  output_valid, output_x, output_y, output_ch
    );
endinterface

// File: rtl/conv_ctrl_tiled.sv
// Tiled convolution layer sequencer: walks x, y, ch_in, output group and kernel
// taps, fetching operands, strobing the MAC and handing out finished groups.
module conv_ctrl_tiled #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int PE_LANES           = 4
) (
    input  logic       clk,
    input  logic       arst_n_in,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] conv_kernel_mode,
    input  logic [1:0] conv_stride_mode,
    output logic       running,
    output logic       done,
    output logic       cfg_error,
    conv_ctrl_tiled_if.master bus
);
    localparam logic [31:0] FMW    = 32'(FEATURE_MAP_WIDTH);
    localparam logic [31:0] FMH    = 32'(FEATURE_MAP_HEIGHT);
    localparam logic [31:0] CH_MAX = 32'(INPUT_NB_CHANNELS - 1);
    localparam logic [31:0] GRP_MAX = 32'(OUTPUT_NB_CHANNELS / PE_LANES - 1);
    localparam logic [31:0] LANES  = 32'(PE_LANES);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MAC, S_OUT} state_t;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d, y_q, y_d, ch_q, ch_d, grp_q, grp_d, kv_q, kv_d, kh_q, kh_d;
    logic [31:0] k_q, k_d, s_q, s_d;
    logic [31:0] ox_q, ox_d, oy_q, oy_d, och_q, och_d;
    logic        a_held_q, a_held_d, b_held_q, b_held_d;
    logic        last_q, last_d;
    logic        done_q, done_d, cfg_err_q, cfg_err_d;

    logic last_kh, last_kv, last_grp, last_ch, last_y, last_x;

    assign last_kh  = (kh_q == k_q - 32'd1);
    assign last_kv  = (kv_q == k_q - 32'd1);
    assign last_grp = (grp_q == GRP_MAX);
    assign last_ch  = (ch_q == CH_MAX);
    assign last_y   = (y_q >= FMH - s_q);
    assign last_x   = (x_q >= FMW - s_q);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            ch_q      <= '0;
            grp_q     <= '0;
            kv_q      <= '0;
            kh_q      <= '0;
            k_q       <= 32'd1;
            s_q       <= 32'd1;
            ox_q      <= '0;
            oy_q      <= '0;
            och_q     <= '0;
            a_held_q  <= 1'b0;
            b_held_q  <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ch_q      <= ch_d;
            grp_q     <= grp_d;
            kv_q      <= kv_d;
            kh_q      <= kh_d;
            k_q       <= k_d;
            s_q       <= s_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            och_q     <= och_d;
            a_held_q  <= a_held_d;
            b_held_q  <= b_held_d;
            last_q    <= last_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ch_d      = ch_q;
        grp_d     = grp_q;
        kv_d      = kv_q;
        kh_d      = kh_q;
        k_d       = k_q;
        s_d       = s_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        och_d     = och_q;
        a_held_d  = a_held_q;
        b_held_d  = b_held_q;
        last_d    = last_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        if (state_q == S_IDLE) begin
            if (start && !abort) begin
                if (conv_kernel_mode == 2'd3 || conv_stride_mode == 2'd3) begin
                    cfg_err_d = 1'b1;
                end else begin
                    k_d      = {29'd0, conv_kernel_mode, 1'b1};
                    s_d      = 32'd1 << conv_stride_mode;
                    x_d      = '0;
                    y_d      = '0;
                    ch_d     = '0;
                    grp_d    = '0;
                    kv_d     = '0;
                    kh_d     = '0;
                    ox_d     = '0;
                    oy_d     = '0;
                    och_d    = '0;
                    a_held_d = 1'b0;
                    b_held_d = 1'b0;
                    last_d   = 1'b0;
                    state_d  = S_FETCH;
                end
            end
        end else if (abort) begin
            state_d  = S_IDLE;
            x_d      = '0;
            y_d      = '0;
            ch_d     = '0;
            grp_d    = '0;
            kv_d     = '0;
            kh_d     = '0;
            ox_d     = '0;
            oy_d     = '0;
            och_d    = '0;
            a_held_d = 1'b0;
            b_held_d = 1'b0;
            last_d   = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    a_held_d = a_held_q | bus.write_a;
                    b_held_d = b_held_q | bus.write_b;
                    if (a_held_d && b_held_d) state_d = S_MAC;
                end
                S_MAC: begin
                    a_held_d = 1'b0;
                    b_held_d = 1'b0;
                    // Nested odometer, innermost tap first, outermost x last.
                    if (!last_kh) kh_d = kh_q + 32'd1;
                    else begin
                        kh_d = '0;
                        if (!last_kv) kv_d = kv_q + 32'd1;
                        else begin
                            kv_d = '0;
                            if (!last_grp) grp_d = grp_q + 32'd1;
                            else begin
                                grp_d = '0;
                                if (!last_ch) ch_d = ch_q + 32'd1;
                                else begin
                                    ch_d = '0;
                                    if (!last_y) y_d = y_q + s_q;
                                    else begin
                                        y_d = '0;
                                        x_d = last_x ? '0 : x_q + s_q;
                                    end
                                end
                            end
                        end
                    end
                    if (last_ch && last_kv && last_kh) begin
                        state_d = S_OUT;
                        ox_d    = x_q;
                        oy_d    = y_q;
                        och_d   = grp_q * LANES;
                        last_d  = last_x && last_y && last_grp;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_OUT: begin
                    if (bus.output_ready) begin
                        if (last_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            last_d  = 1'b0;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.a_ready                 = 1'b0;
        bus.b_ready                 = 1'b0;
        bus.write_a                 = 1'b0;
        bus.write_b                 = 1'b0;
        bus.mac_valid               = 1'b0;
        bus.mac_accumulate_internal = 1'b0;
        bus.mac_accumulate_with_0   = 1'b0;
        bus.mem_we                  = 1'b0;
        bus.mem_re                  = 1'b0;
        bus.mem_write_addr          = '0;
        bus.mem_read_addr           = '0;
        bus.output_valid            = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.a_ready = !a_held_q;
                bus.b_ready = !b_held_q;
                bus.write_a = bus.a_valid && !a_held_q;
                bus.write_b = bus.b_valid && !b_held_q;
            end
            S_MAC: begin
                bus.mac_valid               = 1'b1;
                bus.mac_accumulate_internal = !(kv_q == 32'd0 && kh_q == 32'd0);
                bus.mac_accumulate_with_0   = (ch_q == 32'd0) && (kv_q == 32'd0) && (kh_q == 32'd0);
                bus.mem_re                  = (kv_q == 32'd0) && (kh_q == 32'd0);
                bus.mem_we                  = last_kv && last_kh;
                bus.mem_read_addr           = LOG2_OF_MEM_HEIGHT'(grp_q);
                bus.mem_write_addr          = LOG2_OF_MEM_HEIGHT'(grp_q);
            end
            S_OUT: bus.output_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.output_x  = ox_q;
    assign bus.output_y  = oy_q;
    assign bus.output_ch = och_q;
    assign running       = (state_q != S_IDLE);
    assign done          = done_q;
    assign cfg_error     = cfg_err_q;
endmodule

// File: tb/tb_conv_ctrl_tiled.sv
// Scoreboard bench for conv_ctrl_tiled on a 4x4 map, 2 input / 4 output channels.
module tb_conv_ctrl_tiled;
    localparam int W = 4, H = 4, IN = 2, OUTC = 4, L = 2, AW = 4;

    logic       clk = 1'b0;
    logic       arst_n_in, start, abort;
    logic [1:0] km, sm;
    logic       running, done, cfg_error;

    always #5 clk = ~clk;

    conv_ctrl_tiled_if #(.AW(AW)) bus_if ();

    conv_ctrl_tiled #(
        .LOG2_OF_MEM_HEIGHT(AW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS(IN), .OUTPUT_NB_CHANNELS(OUTC), .PE_LANES(L)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .abort(abort),
        .conv_kernel_mode(km), .conv_stride_mode(sm),
        .running(running), .done(done), .cfg_error(cfg_error), .bus(bus_if)
    );

    typedef struct { int x; int y; int ch; } coord_t;
    coord_t exp_q[$];

    int total = 0, bad = 0;
    int mac_n = 0, int_n = 0, w0_n = 0, re_n = 0, we_n = 0, out_n = 0, done_n = 0;
    int m0, i0, w00, r0, we0, o0, d0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            #2;
            if (bus_if.mac_valid) begin
                mac_n++;
                if (bus_if.mac_accumulate_internal) int_n++;
                if (bus_if.mac_accumulate_with_0)   w0_n++;
                if (bus_if.mem_re)                  re_n++;
                if (bus_if.mem_we)                  we_n++;
            end
            if (done) done_n++;
            if (bus_if.output_valid && bus_if.output_ready) begin
                out_n++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got x=%0d y=%0d ch=%0d expected none",
                             bus_if.output_x, bus_if.output_y, bus_if.output_ch);
                end else begin
                    coord_t e;
                    e = exp_q.pop_front();
                    $display("out x=%0d y=%0d ch=%0d", bus_if.output_x, bus_if.output_y, bus_if.output_ch);
                    check("out_x", bus_if.output_x, e.x);
                    check("out_y", bus_if.output_y, e.y);
                    check("out_ch", bus_if.output_ch, e.ch);
                end
            end
        end
    endtask

    task automatic push_layer(input int s);
        coord_t c;
        for (int x = 0; x < W; x += s)
            for (int y = 0; y < H; y += s)
                for (int g = 0; g < OUTC / L; g++) begin
                    c.x = x; c.y = y; c.ch = g * L;
                    exp_q.push_back(c);
                end
    endtask

    task automatic start_layer(input logic [1:0] k, input logic [1:0] s);
        @(negedge clk);
        m0 = mac_n; i0 = int_n; w00 = w0_n; r0 = re_n; we0 = we_n; o0 = out_n; d0 = done_n;
        km = k; sm = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_layer(input string tag, input int e_mac, input int e_out, input int e_w0,
                                input int e_int, input int e_re, input int e_we);
        int cyc;
        bit seen;
        cyc = 0; seen = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            if (done) seen = 1;
            cyc++;
        end
        check({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        check({tag, "_macs"}, mac_n - m0, e_mac);
        check({tag, "_outs"}, out_n - o0, e_out);
        check({tag, "_with0"}, w0_n - w00, e_w0);
        check({tag, "_internal"}, int_n - i0, e_int);
        check({tag, "_mem_re"}, re_n - r0, e_re);
        check({tag, "_mem_we"}, we_n - we0, e_we);
        check({tag, "_done_count"}, done_n - d0, 1);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_running"}, running, 0);
        $display("layer %s complete", tag);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_running"}, running, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_error"}, cfg_error, 0);
        check({tag, "_a_ready"}, bus_if.a_ready, 0);
        check({tag, "_b_ready"}, bus_if.b_ready, 0);
        check({tag, "_mac_valid"}, bus_if.mac_valid, 0);
        check({tag, "_mem_re"}, bus_if.mem_re, 0);
        check({tag, "_mem_we"}, bus_if.mem_we, 0);
        check({tag, "_output_valid"}, bus_if.output_valid, 0);
        check({tag, "_output_x"}, bus_if.output_x, 0);
        check({tag, "_output_y"}, bus_if.output_y, 0);
        check({tag, "_output_ch"}, bus_if.output_ch, 0);
    endtask

    initial begin
        int n, cyc;
        bit found;
        arst_n_in = 1'b0; start = 1'b0; abort = 1'b0; km = 2'd0; sm = 2'd0;
        bus_if.a_valid = 1'b0; bus_if.b_valid = 1'b0; bus_if.output_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk);
        arst_n_in = 1'b1;
        bus_if.a_valid = 1'b1; bus_if.b_valid = 1'b1; bus_if.output_ready = 1'b1;

        // 1x1 stride 1; illegal config bits presented mid-layer must be ignored
        push_layer(1);
        start_layer(2'd0, 2'd0);
        km = 2'd3; sm = 2'd3;
        finish_layer("k1s1", 64, 32, 32, 0, 64, 64);

        // 3x3 stride 2
        push_layer(2);
        start_layer(2'd1, 2'd1);
        finish_layer("k3s2", 144, 8, 8, 128, 16, 16);

        // A arrives three cycles ahead of B
        bus_if.a_valid = 1'b1; bus_if.b_valid = 1'b0;
        start_layer(2'd0, 2'd0);
        #1;
        check("stag_a_ready0", bus_if.a_ready, 1);
        check("stag_write_a0", bus_if.write_a, 1);
        check("stag_write_b0", bus_if.write_b, 0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            #1;
            check("stag_a_ready_after", bus_if.a_ready, 0);
            check("stag_write_a_after", bus_if.write_a, 0);
            check("stag_b_ready_wait", bus_if.b_ready, 1);
            check("stag_mac_early", bus_if.mac_valid, 0);
        end
        @(negedge clk);
        bus_if.b_valid = 1'b1;
        #1;
        check("stag_write_b", bus_if.write_b, 1);
        check("stag_mac_same", bus_if.mac_valid, 0);
        @(negedge clk);
        bus_if.b_valid = 1'b0;
        #1;
        check("stag_mac_next", bus_if.mac_valid, 1);
        check("stag_write_a_mac", bus_if.write_a, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 check("stag_abort_running", running, 0);
        $display("stagger sequence complete");
        bus_if.a_valid = 1'b1; bus_if.b_valid = 1'b1;

        // output backpressure for five cycles on the first group
        push_layer(1);
        bus_if.output_ready = 1'b0;
        start_layer(2'd0, 2'd0);
        found = 0; cyc = 0;
        while (!found && cyc < 200) begin
            #1;
            if (bus_if.output_valid) found = 1;
            else begin @(negedge clk); cyc++; end
        end
        check("bp_out_seen", found, 1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", bus_if.output_valid, 1);
            check("bp_x", bus_if.output_x, 0);
            check("bp_y", bus_if.output_y, 0);
            check("bp_ch", bus_if.output_ch, 0);
            check("bp_a_ready", bus_if.a_ready, 0);
            check("bp_b_ready", bus_if.b_ready, 0);
            @(negedge clk);
            #1;
        end
        bus_if.output_ready = 1'b1;
        finish_layer("backpressure", 64, 32, 32, 0, 64, 64);

        // rejected configurations and abort-over-start in IDLE
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            km = (t == 0) ? 2'd0 : 2'd3;
            sm = (t == 0) ? 2'd3 : 2'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            check("cfg_err_pulse", cfg_error, 1);
            check("cfg_err_running", running, 0);
            @(negedge clk);
            #1;
            check("cfg_err_cleared", cfg_error, 0);
            check("cfg_err_still_idle", running, 0);
            $display("cfg rejection %0d complete", t);
        end
        @(negedge clk);
        km = 2'd0; sm = 2'd0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1 check("abort_beats_start", running, 0);

        // abort during the 20th MAC of a 3x3 stride-2 layer
        start_layer(2'd1, 2'd1);
        n = 0; cyc = 0;
        while (n < 20 && cyc < 2000) begin
            @(negedge clk);
            #1;
            if (bus_if.mac_valid) n++;
            cyc++;
        end
        check("abort_mac_reached", n, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (4) @(negedge clk);
        check("abort_no_done", done_n - d0, 0);
        check("abort_no_output", out_n - o0, 0);

        // reset asserted while waiting for operands
        bus_if.a_valid = 1'b0; bus_if.b_valid = 1'b0;
        start_layer(2'd0, 2'd0);
        repeat (2) @(negedge clk);
        #1 check("pre_reset_running", running, 1);
        arst_n_in = 1'b0;
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        arst_n_in = 1'b1;
        bus_if.a_valid = 1'b1; bus_if.b_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("post_reset_idle", running, 0);
        check("post_reset_no_done", done_n - d0, 0);

        push_layer(1);
        start_layer(2'd0, 2'd0);
        finish_layer("recover", 64, 32, 32, 0, 64, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
